// File: rtl/stage3_writeback.sv
// Writeback pipeline register plus 32x32 register file with two bypassed read ports.
// Also keeps a saturating count of committed writes for debug visibility.
module stage3_writeback #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] S2_ALUResult,
   input  logic [4:0]        S2_writeselect,
   input  logic              S2_WriteEnable,
   input  logic [4:0]        S1_readselect1,
   input  logic [4:0]        S1_readselect2,
   output logic [DATA_W-1:0] S1_readData1,
   output logic [DATA_W-1:0] S1_readData2,
   output logic [DATA_W-1:0] S3_ALUResult,
   output logic [4:0]        S3_writeselect,
   output logic              S3_WriteEnable,
   output logic [CNT_W-1:0]  S3_writeCount
);

   localparam int NUM_PORTS = 2;

   logic [31:0][DATA_W-1:0]        rf;
   logic                           commit;
   logic [NUM_PORTS-1:0][4:0]      rsel;
   logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;

   // Index 0 is never written, so the array slot stays at its reset value.
   assign commit = S3_WriteEnable && (S3_writeselect != 5'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf             <= '0;
         S3_ALUResult   <= '0;
         S3_writeselect <= '0;
         S3_WriteEnable <= 1'b0;
         S3_writeCount  <= '0;
      end else begin
         S3_ALUResult   <= S2_ALUResult;
         S3_writeselect <= S2_writeselect;
         S3_WriteEnable <= S2_WriteEnable;
         if (commit) begin
            rf[S3_writeselect] <= S3_ALUResult;
            if (S3_writeCount != {CNT_W{1'b1}})
               S3_writeCount <= S3_writeCount + 1'b1;
         end
      end
   end

   assign rsel = {S1_readselect2, S1_readselect1};

   // Bypass from S3 covers the one-cycle gap before the array holds the value.
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
      assign rdata[p] = (rsel[p] == 5'd0)                                 ? '0 :
                        (S3_WriteEnable && (S3_writeselect == rsel[p]))   ? S3_ALUResult :
                                                                            rf[rsel[p]];
   end

   assign S1_readData1 = rdata[0];
   assign S1_readData2 = rdata[1];

endmodule
